// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, access size codes and requester ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    RESP     = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Size code 3 is illegal and is reported the same way as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables / replicated write data for the outgoing access,
// and lane selection plus sign/zero extension for returning load data.
module lsu_lane_align
  import mem_arb_pkg::*;
(
  input  logic        st_we,
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_mwdata,
  output logic        st_misalign,
  input  logic [31:0] ld_rdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_misalign = is_misaligned(st_size, st_lo);
    st_be       = 4'b1111;
    st_mwdata   = '0;
    if (st_we) begin
      case (st_size)
        SZ_B: begin
          st_be     = 4'b0001 << st_lo;
          st_mwdata = {4{st_wdata[7:0]}};
        end
        SZ_H: begin
          st_be     = 4'b0011 << st_lo;
          st_mwdata = {2{st_wdata[15:0]}};
        end
        default: begin
          st_be     = 4'b1111;
          st_mwdata = st_wdata;
        end
      endcase
    end
  end

  always_comb begin
    ld_shifted = ld_rdata >> {ld_lo, 3'b000};
    case (ld_size)
      SZ_B:    ld_data = ld_unsigned ? {24'b0, ld_shifted[7:0]}
                                     : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H:    ld_data = ld_unsigned ? {16'b0, ld_shifted[15:0]}
                                     : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LS has fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  src_e              src_q, src_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lo_q, lo_d;
  logic              uns_q, uns_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              ls_rvalid_q, ls_rvalid_d, ls_err_q, ls_err_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic              grant, ls_wins;
  logic              req_we, req_uns;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, ld_data;
  logic              al_misalign;
  logic              done, done_err;
  logic [31:0]       done_data;
  src_e              done_src;

`ifdef MEM_ARB_RR_EN
  src_e last_q, last_d;
  assign ls_wins = ls_req & (~if_req | (last_q == SRC_IF));
`else
  assign ls_wins = ls_req;
`endif

  // Grants are suppressed while reset is held so every output reads 0 during reset.
  assign grant  = (state_q == IDLE) & (if_req | ls_req) & ~rst;
  assign ls_gnt = grant & ls_wins;
  assign if_gnt = grant & ~ls_wins;

  assign req_we    = ls_wins ? ls_we       : 1'b0;
  assign req_size  = ls_wins ? ls_size     : SZ_W;
  assign req_uns   = ls_wins ? ls_unsigned : 1'b0;
  assign req_addr  = ls_wins ? ls_addr     : if_addr;
  assign req_wdata = ls_wins ? ls_wdata    : 32'b0;

  lsu_lane_align u_align (
    .st_we       (req_we),
    .st_size     (req_size),
    .st_lo       (req_addr[1:0]),
    .st_wdata    (req_wdata),
    .st_be       (al_be),
    .st_mwdata   (al_wdata),
    .st_misalign (al_misalign),
    .ld_rdata    (mem_rdata),
    .ld_size     (size_q),
    .ld_lo       (lo_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    size_d      = size_q;
    lo_d        = lo_q;
    uns_d       = uns_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done        = 1'b0;
    done_err    = 1'b0;
    done_data   = 32'b0;
    done_src    = src_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          src_d       = ls_wins ? SRC_LS : SRC_IF;
          size_d      = req_size;
          lo_d        = req_addr[1:0];
          uns_d       = req_uns;
          cnt_d       = '0;
          mem_we_d    = req_we;
          mem_be_d    = al_be;
          mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = al_wdata;
`ifdef MEM_ARB_RR_EN
          last_d      = src_d;
`endif
          if (al_misalign) begin
            state_d  = RESP;
            done     = 1'b1;
            done_err = 1'b1;
            done_src = src_d;
          end else begin
            state_d = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        // An ack on the final counted cycle still completes without error.
        if (mem_ack) begin
          state_d   = RESP;
          done      = 1'b1;
          done_data = mem_we_q ? 32'b0 : ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    ls_err_d    = ls_err_q;
    if (done) begin
      if (done_src == SRC_LS) begin
        ls_rvalid_d = 1'b1;
        ls_rdata_d  = done_data;
        ls_err_d    = done_err;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = done_data;
        if_err_d    = done_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= SRC_IF;
      size_q      <= SZ_B;
      lo_q        <= 2'b00;
      uns_q       <= 1'b0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'b0;
      if_err_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= 32'b0;
      ls_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      size_q      <= size_d;
      lo_q        <= lo_d;
      uns_q       <= uns_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= SRC_IF;
    else     last_q <= last_d;
  end
`endif

  assign mem_req   = (state_q == WAIT_MEM);
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_err    = ls_err_q;

endmodule
